// File: rtl/mips_mc_sequencer_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encoding,
// control_type codes and the counter width.
package mips_mc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC    = 3'd2,
        ST_MEM     = 3'd3,
        ST_ADDM_EX = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    // control_type from the decoder: anything but sequential redirects the PC
    localparam logic [1:0] CT_SEQ    = 2'd0;
    localparam logic [1:0] CT_BRANCH = 2'd1;
    localparam logic [1:0] CT_JUMP   = 2'd2;
    localparam logic [1:0] CT_JR     = 2'd3;

    localparam int CNT_W = 32;

    function automatic logic needs_mem(input logic mem_read, input logic word_we,
                                       input logic byte_we, input logic addm);
        return mem_read | word_we | byte_we | addm;
    endfunction

endpackage

// File: rtl/mips_mc_sequencer_perf_counter.sv
// Saturating event counter used for the optional performance counters
// (instantiated only when MIPS_MC_PERF_CNT_EN is defined).
module mips_mc_perf_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer driving a single shared memory port.
// Optional performance counters are enabled with MIPS_MC_PERF_CNT_EN.
import mips_mc_sequencer_pkg::*;

module mips_mc_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        writeenable,
    input  logic        mem_read,
    input  logic        word_we,
    input  logic        byte_we,
    input  logic        addm,
    input  logic        except,
    input  logic [1:0]  control_type,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_wr_word,
    output logic        mem_wr_byte,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        rf_we,
    output logic        alu_b_mdr,
    output logic        instr_done,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);

    state_e r_state;
    state_e w_next;

    logic w_mem_req;
    logic w_mem_addr_sel;
    logic w_mem_wr_word;
    logic w_mem_wr_byte;
    logic w_ir_we;
    logic w_mdr_we;
    logic w_pc_we;
    logic w_pc_src;
    logic w_rf_we;
    logic w_alu_b_mdr;
    logic w_instr_done;
    logic w_halted;

    always_comb begin
        w_next         = r_state;
        w_mem_req      = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_mem_wr_word  = 1'b0;
        w_mem_wr_byte  = 1'b0;
        w_ir_we        = 1'b0;
        w_mdr_we       = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_src       = 1'b0;
        w_rf_we        = 1'b0;
        w_alu_b_mdr    = 1'b0;
        w_instr_done   = 1'b0;
        w_halted       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = ST_DECODE;
                end
            end

            ST_DECODE: begin
                w_next = except ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                if (control_type != CT_SEQ) begin
                    w_pc_we      = 1'b1;
                    w_pc_src     = 1'b1;
                    w_instr_done = 1'b1;
                    w_next       = ST_FETCH;
                end else if (needs_mem(mem_read, word_we, byte_we, addm)) begin
                    w_next = ST_MEM;
                end else begin
                    w_next = ST_WB;
                end
            end

            ST_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_wr_word  = word_we;
                w_mem_wr_byte  = byte_we;
                // Stores take priority over addm, and addm over a plain load.
                if (mem_ready) begin
                    if (word_we || byte_we) begin
                        w_instr_done = 1'b1;
                        w_next       = ST_FETCH;
                    end else if (addm) begin
                        w_mdr_we = 1'b1;
                        w_next   = ST_ADDM_EX;
                    end else begin
                        w_mdr_we = 1'b1;
                        w_next   = ST_WB;
                    end
                end
            end

            ST_ADDM_EX: begin
                w_alu_b_mdr = 1'b1;
                w_next      = ST_WB;
            end

            ST_WB: begin
                w_rf_we      = writeenable;
                w_alu_b_mdr  = addm;
                w_instr_done = 1'b1;
                w_next       = ST_FETCH;
            end

            ST_HALT: begin
                w_halted = 1'b1;
                w_next   = ST_HALT;
            end

            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Qualifying with reset lets strobes drop the instant reset asserts,
    // even though the state register itself already reads FETCH.
    assign mem_req      = reset & w_mem_req;
    assign mem_addr_sel = reset & w_mem_addr_sel;
    assign mem_wr_word  = reset & w_mem_wr_word;
    assign mem_wr_byte  = reset & w_mem_wr_byte;
    assign ir_we        = reset & w_ir_we;
    assign mdr_we       = reset & w_mdr_we;
    assign pc_we        = reset & w_pc_we;
    assign pc_src       = reset & w_pc_src;
    assign rf_we        = reset & w_rf_we;
    assign alu_b_mdr    = reset & w_alu_b_mdr;
    assign instr_done   = reset & w_instr_done;
    assign halted       = reset & w_halted;
    assign state        = r_state;

`ifdef MIPS_MC_PERF_CNT_EN
    mips_mc_perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (1'b1),
        .o_count (cycle_count)
    );

    mips_mc_perf_counter #(.W(CNT_W)) u_instr_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (instr_done),
        .o_count (instr_count)
    );
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Self-checking bench for mips_mc_sequencer: per-instruction expected output
// sequences built from the instruction-class rules, compared every cycle.
`timescale 1ns/1ps
module tb_mips_mc_sequencer;
    import mips_mc_sequencer_pkg::*;

    localparam int VW = 15;
    localparam int W  = 1 + VW + 64;

    localparam int K_ALU  = 0;
    localparam int K_BR   = 1;
    localparam int K_LW   = 2;
    localparam int K_SW   = 3;
    localparam int K_SB   = 4;
    localparam int K_ADDM = 5;
    localparam int K_EXC  = 6;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        writeenable = 1'b0;
    logic        mem_read = 1'b0;
    logic        word_we = 1'b0;
    logic        byte_we = 1'b0;
    logic        addm = 1'b0;
    logic        except = 1'b0;
    logic [1:0]  control_type = 2'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic        mem_addr_sel;
    logic        mem_wr_word;
    logic        mem_wr_byte;
    logic        ir_we;
    logic        mdr_we;
    logic        pc_we;
    logic        pc_src;
    logic        rf_we;
    logic        alu_b_mdr;
    logic        instr_done;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    mips_mc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .writeenable  (writeenable),
        .mem_read     (mem_read),
        .word_we      (word_we),
        .byte_we      (byte_we),
        .addm         (addm),
        .except       (except),
        .control_type (control_type),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_addr_sel (mem_addr_sel),
        .mem_wr_word  (mem_wr_word),
        .mem_wr_byte  (mem_wr_byte),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .rf_we        (rf_we),
        .alu_b_mdr    (alu_b_mdr),
        .instr_done   (instr_done),
        .halted       (halted),
        .state        (state),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    always #5 clock = ~clock;

    logic [W-1:0] exp_q[$];
    logic [31:0]  m_cycles = 32'd0;
    logic [31:0]  m_instr  = 32'd0;
    int           n_checks = 0;
    int           n_errs   = 0;

    // Per-instruction observations of the DUT, used by the literal checks.
    int           mon_cyc;
    int           mon_done_cyc;
    int           mon_rf_cnt;
    int           mon_rf_cyc;
    int           mon_mdr_cnt;
    int           mon_pc_cnt;
    int           mon_req_cnt;
    int           mon_halt_cnt;
    logic [7:0]   mon_pc_src;
    logic [15:0]  mon_alub_mask;
    logic [2:0]   mon_states[16];
    int           len;

    function automatic logic [VW-1:0] pk(input logic [2:0] st, input logic req, input logic sel,
                                         input logic ww, input logic wb, input logic ir,
                                         input logic mdr, input logic pcwe, input logic pcsrc,
                                         input logic rf, input logic alub, input logic done,
                                         input logic halt);
        return {st, req, sel, ww, wb, ir, mdr, pcwe, pcsrc, rf, alub, done, halt};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return pk(state, mem_req, mem_addr_sel, mem_wr_word, mem_wr_byte, ir_we, mdr_we,
                  pc_we, pc_src, rf_we, alu_b_mdr, instr_done, halted);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [W-1:0]    e;
        logic [VW-1:0]   e_vec;
        e = exp_q.pop_front();
        e_vec = e[W-2 -: VW];
        check("outputs", 64'(dut_vec()), 64'(e_vec));
        check("cycle_count", 64'(cycle_count), 64'(e[63:32]));
        check("instr_count", 64'(instr_count), 64'(e[31:0]));
        if (e[W-1]) begin
            mon_cyc = 0; mon_done_cyc = 0; mon_rf_cnt = 0; mon_rf_cyc = 0;
            mon_mdr_cnt = 0; mon_pc_cnt = 0; mon_req_cnt = 0; mon_halt_cnt = 0;
            mon_pc_src = 8'd0; mon_alub_mask = 16'd0;
            for (int i = 0; i < 16; i++) mon_states[i] = 3'd7;
        end
        mon_cyc++;
        if (mon_cyc <= 16) mon_states[mon_cyc-1] = state;
        if (instr_done) mon_done_cyc = mon_cyc;
        if (rf_we) begin mon_rf_cnt++; mon_rf_cyc = mon_cyc; end
        if (mdr_we) mon_mdr_cnt++;
        if (pc_we) begin mon_pc_cnt++; mon_pc_src = {mon_pc_src[6:0], pc_src}; end
        if (mem_req) mon_req_cnt++;
        if (halted) mon_halt_cnt++;
        if (alu_b_mdr && mon_cyc < 16) mon_alub_mask[mon_cyc] = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, sample 2ns later, before the rising edge.
    task automatic cycle(input logic rdy, input logic [VW-1:0] vec, input logic first);
        logic [31:0] ec;
        logic [31:0] ei;
        mem_ready = rdy;
`ifdef MIPS_MC_PERF_CNT_EN
        ec = m_cycles;
        ei = m_instr;
`else
        ec = 32'd0;
        ei = 32'd0;
`endif
        exp_q.push_back({first, vec, ec, ei});
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        if (vec[1] && m_instr != 32'hFFFF_FFFF) m_instr = m_instr + 32'd1;
        #2;
        compare();
        @(negedge clock);
    endtask

    task automatic rand_dec();
        writeenable  = 1'($urandom);
        mem_read     = 1'($urandom);
        word_we      = 1'($urandom);
        byte_we      = 1'($urandom);
        addm         = 1'($urandom);
        except       = 1'($urandom);
        control_type = 2'($urandom);
    endtask

    task automatic set_dec(input int kind, input logic we);
        writeenable  = we;
        mem_read     = (kind == K_LW);
        word_we      = (kind == K_SW);
        byte_we      = (kind == K_SB);
        addm         = (kind == K_ADDM);
        except       = (kind == K_EXC);
        control_type = (kind == K_BR) ? 2'($urandom_range(1, 3)) : CT_SEQ;
    endtask

    // Expected behaviour per instruction class: fetch (with waits), decode,
    // then either branch retire, a memory step (with waits), addm step, writeback.
    task automatic run_instr(input int kind, input int fw, input int mw, input logic we,
                             output int n);
        logic is_store;
        logic is_mem;
        n = 0;
        is_store = (kind == K_SW) || (kind == K_SB);
        is_mem   = is_store || (kind == K_LW) || (kind == K_ADDM);
        for (int i = 0; i < fw; i++) begin
            rand_dec();
            cycle(1'b0, pk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), i == 0);
            n++;
        end
        rand_dec();
        cycle(1'b1, pk(ST_FETCH, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), fw == 0);
        n++;
        set_dec(kind, we);
        cycle(1'($urandom), pk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        n++;
        if (kind == K_EXC) return;
        if (kind == K_BR) begin
            cycle(1'($urandom), pk(ST_EXEC, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0), 1'b0);
            n++;
            return;
        end
        cycle(1'($urandom), pk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        n++;
        if (is_mem) begin
            for (int i = 0; i < mw; i++) begin
                cycle(1'b0, pk(ST_MEM, 1, 1, kind == K_SW, kind == K_SB, 0, 0, 0, 0, 0, 0, 0, 0),
                      1'b0);
                n++;
            end
            cycle(1'b1, pk(ST_MEM, 1, 1, kind == K_SW, kind == K_SB, 0, !is_store, 0, 0, 0, 0,
                           is_store, 0), 1'b0);
            n++;
            if (is_store) return;
        end
        if (kind == K_ADDM) begin
            cycle(1'($urandom), pk(ST_ADDM_EX, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
            n++;
        end
        cycle(1'($urandom), pk(ST_WB, 0, 0, 0, 0, 0, 0, 0, 0, we, kind == K_ADDM, 1, 0), 1'b0);
        n++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_outputs"}, 64'(dut_vec()),
              64'(pk(ST_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
        check({tag, "_instr_count"}, 64'(instr_count), 64'd0);
    endtask

    // Enter with reset already low; hold it a few edges and release mid-cycle.
    task automatic finish_reset();
        mem_ready = 1'b1;
        rand_dec();
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("held_reset");
        @(negedge clock);
        reset    = 1'b1;
        m_cycles = 32'd0;
        m_instr  = 32'd0;
    endtask

    initial begin
        mon_cyc = 0; mon_done_cyc = 0; mon_rf_cnt = 0; mon_rf_cyc = 0;
        mon_mdr_cnt = 0; mon_pc_cnt = 0; mon_req_cnt = 0; mon_halt_cnt = 0;
        mon_pc_src = 8'd0; mon_alub_mask = 16'd0;
        for (int i = 0; i < 16; i++) mon_states[i] = 3'd7;

        #1;
        check_reset_values("por");
        finish_reset();

        // add, no waits: FETCH, DECODE, EXEC, WB
        run_instr(K_ALU, 0, 0, 1'b1, len);
        check("add_model_len", 64'(len), 64'd4);
        check("add_states", 64'({mon_states[0], mon_states[1], mon_states[2], mon_states[3]}),
              64'({ST_FETCH, ST_DECODE, ST_EXEC, ST_WB}));
        check("add_rf_we_cycle", 64'(mon_rf_cyc), 64'd4);
        check("add_done_cycle", 64'(mon_done_cyc), 64'd4);
`ifdef MIPS_MC_PERF_CNT_EN
        check("add_instr_count", 64'(instr_count), 64'd1);
`else
        check("add_instr_count", 64'(instr_count), 64'd0);
`endif

        // lw, 2 fetch waits and 1 memory wait
        run_instr(K_LW, 2, 1, 1'b1, len);
        check("lw_model_len", 64'(len), 64'd8);
        check("lw_done_cycle", 64'(mon_done_cyc), 64'd8);
        check("lw_mdr_we_count", 64'(mon_mdr_cnt), 64'd1);
        check("lw_rf_we_count", 64'(mon_rf_cnt), 64'd1);

        // beq: pc_we twice, sequential then target
        run_instr(K_BR, 0, 0, 1'b1, len);
        check("beq_model_len", 64'(len), 64'd3);
        check("beq_done_cycle", 64'(mon_done_cyc), 64'd3);
        check("beq_pc_we_count", 64'(mon_pc_cnt), 64'd2);
        check("beq_pc_src_order", 64'(mon_pc_src), 64'h01);
        check("beq_rf_we_count", 64'(mon_rf_cnt), 64'd0);

        // addm: alu_b_mdr in cycles 5 and 6, rf_we in 6
        run_instr(K_ADDM, 0, 0, 1'b1, len);
        check("addm_model_len", 64'(len), 64'd6);
        check("addm_alub_cycles", 64'(mon_alub_mask), 64'h0060);
        check("addm_rf_we_cycle", 64'(mon_rf_cyc), 64'd6);
        check("addm_state5", 64'(mon_states[4]), 64'(ST_ADDM_EX));

        // sw: retires out of MEM, never writes the register file
        run_instr(K_SW, 0, 0, 1'b1, len);
        check("sw_model_len", 64'(len), 64'd4);
        check("sw_done_cycle", 64'(mon_done_cyc), 64'd4);
        check("sw_rf_we_count", 64'(mon_rf_cnt), 64'd0);

        // randomized instruction mix with random wait states
        for (int k = 0; k < 150; k++) begin
            int kind;
            int fw;
            int mw;
            kind = $urandom_range(0, 5);
            fw   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            mw   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
            run_instr(kind, fw, mw, 1'($urandom), len);
        end

        // sw interrupted by reset while stalled in MEM
        rand_dec();
        cycle(1'b1, pk(ST_FETCH, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 1'b1);
        set_dec(K_SW, 1'b0);
        cycle(1'b0, pk(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cycle(1'b1, pk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        cycle(1'b0, pk(ST_MEM, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        mem_ready = 1'b0;
        #1;
        check("sw_wr_before_reset", 64'(mem_wr_word), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("sw_wr_after_reset", 64'(mem_wr_word), 64'd0);
        check("sw_req_after_reset", 64'(mem_req), 64'd0);
        check("sw_no_retire", 64'(instr_done), 64'd0);
        check_reset_values("mid_mem_reset");
        @(negedge clock);
        finish_reset();
        run_instr(K_ALU, 0, 0, 1'b1, len);
        check("post_reset_first_state", 64'(mon_states[0]), 64'(ST_FETCH));
        check("post_reset_done_cycle", 64'(mon_done_cyc), 64'd4);

        // exception in DECODE: terminal HALT
        run_instr(K_EXC, 1, 0, 1'b1, len);
        for (int i = 0; i < 20; i++) begin
            rand_dec();
            cycle(1'($urandom), pk(ST_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
        end
        check("halt_mem_req_count", 64'(mon_req_cnt), 64'd2);
        check("halt_halted_count", 64'(mon_halt_cnt), 64'd20);
        reset = 1'b0;
        #1;
        check("halt_reset_state", 64'(state), 64'(ST_FETCH));
        check("halt_reset_halted", 64'(halted), 64'd0);
        @(negedge clock);
        finish_reset();
        run_instr(K_LW, 0, 0, 1'b1, len);
        check("after_halt_lw_done", 64'(mon_done_cyc), 64'd5);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
